ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, default timing constants and
// the parity helper used by both the host transmitter and keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_state_e;

  localparam logic [15:0] PS2_INHIBIT_CYCLES = 16'd1000;
  localparam logic [15:0] PS2_TIMEOUT_CYCLES = 16'd20000;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus falling-edge detection on
// the synchronized value. All flops idle at 1, the released-line level.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync = sync_reg;
  assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit,
// shifts out 8 data bits, odd parity and stop on device clock falls, then
// samples the device ACK. Aborts with an error if the device stops clocking.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter logic [15:0] TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       clock_oe,
  output logic       data_oe
);

  logic        clk_sync;
  logic        clk_fall;
  logic        data_meta_reg;
  logic        data_sync_reg;
  ps2_state_e  state_reg, state_next;
  logic [7:0]  byte_reg, byte_next;
  logic        parity_reg, parity_next;
  logic [3:0]  edge_cnt_reg, edge_cnt_next;
  logic [15:0] cycle_cnt_reg, cycle_cnt_next;
  logic        data_oe_reg, data_oe_next;
  logic        in_xfer;
  logic        timeout_hit;

  ps2_sync_edge u_clk_sync (
    .clock (clock),
    .reset (reset),
    .line  (device_clock),
    .sync  (clk_sync),
    .fall  (clk_fall)
  );

  // Data line only needs its synchronized level (ACK sample, idle check).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      data_meta_reg <= device_data;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign in_xfer     = (state_reg inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK});
  assign timeout_hit = in_xfer && (cycle_cnt_reg == TIMEOUT_CYCLES);

  // State and datapath registers; reset releases both bus lines at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      byte_reg      <= 8'h00;
      parity_reg    <= 1'b0;
      edge_cnt_reg  <= 4'd0;
      cycle_cnt_reg <= 16'd0;
      data_oe_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_reg      <= byte_next;
      parity_reg    <= parity_next;
      edge_cnt_reg  <= edge_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
      data_oe_reg   <= data_oe_next;
    end
  end

  // Next-state and output decode; data_oe is registered so the line only
  // changes in the cycle after a detected fall.
  always_comb begin
    state_next     = state_reg;
    byte_next      = byte_reg;
    parity_next    = parity_reg;
    edge_cnt_next  = edge_cnt_reg;
    cycle_cnt_next = cycle_cnt_reg;
    data_oe_next   = data_oe_reg;
    tx_ready       = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    clock_oe       = 1'b0;
    data_oe        = data_oe_reg;

    case (state_reg)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          byte_next      = tx_data;
          parity_next    = ps2_odd_parity(tx_data);
          cycle_cnt_next = 16'd0;
          data_oe_next   = 1'b0;
          state_next     = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clock_oe       = 1'b1;
        cycle_cnt_next = cycle_cnt_reg + 16'd1;
        if (cycle_cnt_reg == INHIBIT_CYCLES - 16'd1) begin
          data_oe_next = 1'b1;
          state_next   = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        clock_oe       = 1'b1;
        cycle_cnt_next = 16'd0;
        edge_cnt_next  = 4'd0;
        state_next     = ST_DATA;
      end
      ST_DATA: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          data_oe_next  = ~byte_reg[edge_cnt_reg[2:0]];
          if (edge_cnt_reg == 4'd7) state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          data_oe_next  = ~parity_reg;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          data_oe_next  = 1'b0;
          state_next    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          if (data_sync_reg) error = 1'b1;
          else               done  = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        data_oe_next = 1'b0;
        if (clk_sync && data_sync_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Inter-edge watchdog: restart on every fall, abort when it expires.
    if (in_xfer) begin
      cycle_cnt_next = clk_fall ? 16'd0 : cycle_cnt_reg + 16'd1;
      if (timeout_hit) begin
        done           = 1'b0;
        error          = 1'b1;
        data_oe        = 1'b0;
        data_oe_next   = 1'b0;
        cycle_cnt_next = 16'd0;
        state_next     = ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam logic [15:0] INH = 16'd20;
  localparam logic [15:0] TO  = 16'd300;
  localparam int          H   = 40;   // device half-period in system cycles

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       device_clock, device_data;
  logic       clock_oe, data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;

  assign device_clock = ~(clock_oe | dev_clk_low);
  assign device_data  = ~(data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .device_clock (device_clock),
    .device_data  (device_data),
    .clock_oe     (clock_oe),
    .data_oe      (data_oe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (error) error_cnt++;
    if (done && error) both_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Request a byte and follow the host through INHIBIT and REQUEST into DATA.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clock);
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    n = 0;
    while (clock_oe && !data_oe && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check("inhibit_len", n, {16'd0, INH});
    check("request_start", {30'd0, clock_oe, data_oe}, 32'd3);
    @(negedge clock);
    check("data_entry", {30'd0, clock_oe, data_oe}, 32'd1);
  endtask

  // Device clocks nfalls edges, sampling the line on each rising edge.
  task automatic dev_xfer(input int nfalls, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i-1] = device_data;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check(tag, {31'd0, busy}, 32'd0);
    check("lines_idle", {30'd0, device_clock, device_data}, 32'd3);
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_outs", {27'd0, busy, done, error, clock_oe, data_oe}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_outs", {26'd0, tx_ready, busy, done, error, clock_oe, data_oe}, 32'h20);

    // 0xED with ACK: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt; e0 = error_cnt;
    send(8'hED);
    dev_xfer(11, 1'b1, bits);
    $display("xfer byte=ed bits=%03h", bits);
    check("ed_data", {24'd0, bits[7:0]}, 32'hED);
    check("ed_parity", {31'd0, bits[8]}, 32'd1);
    check("ed_stop", {31'd0, bits[9]}, 32'd1);
    check("ed_busy_release", {31'd0, busy}, 32'd1);
    wait_idle("ed_idle");
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_no_err", error_cnt - e0, 32'd0);

    // 0xF4: parity 0
    d0 = done_cnt; e0 = error_cnt;
    send(8'hF4);
    dev_xfer(11, 1'b1, bits);
    $display("xfer byte=f4 bits=%03h", bits);
    check("f4_data", {24'd0, bits[7:0]}, 32'hF4);
    check("f4_parity", {31'd0, bits[8]}, 32'd0);
    wait_idle("f4_idle");
    check("f4_done", done_cnt - d0, 32'd1);

    // No device clocks: timeout after exactly TO cycles in DATA
    d0 = done_cnt; e0 = error_cnt;
    send(8'h12);
    n = 0;
    while (!error && n < TO + 50) begin
      @(negedge clock);
      n++;
    end
    $display("xfer byte=12 timeout after %0d cycles", n);
    check("to_cycles", n, {16'd0, TO});
    check("to_lines", {30'd0, clock_oe, data_oe}, 32'd0);
    @(negedge clock);
    check("to_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(negedge clock);
    check("to_err_cnt", error_cnt - e0, 32'd1);
    check("to_no_done", done_cnt - d0, 32'd0);

    // NACK: data high at fall 11
    d0 = done_cnt; e0 = error_cnt;
    send(8'h0F);
    dev_xfer(11, 1'b0, bits);
    $display("xfer byte=0f nack bits=%03h", bits);
    wait_idle("nack_idle");
    check("nack_err", error_cnt - e0, 32'd1);
    check("nack_no_done", done_cnt - d0, 32'd0);

    // Reset during bit 4 of 0x37 (bit 3 is 0, so data_oe is driven)
    d0 = done_cnt; e0 = error_cnt;
    send(8'h37);
    dev_xfer(4, 1'b1, bits);
    check("rst_bits", {28'd0, bits[3:0]}, 32'h7);
    check("rst_pre_data_oe", {31'd0, data_oe}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_lines", {30'd0, clock_oe, data_oe}, 32'd0);
    check("rst_mid_idle", {30'd0, tx_ready, busy}, 32'd2);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    $display("xfer byte=37 aborted by reset");
    check("rst_no_pulses", (done_cnt - d0) + (error_cnt - e0), 32'd0);

    // Follow-up 0x55 completes normally
    d0 = done_cnt;
    send(8'h55);
    dev_xfer(11, 1'b1, bits);
    $display("xfer byte=55 bits=%03h", bits);
    check("x55_data", {24'd0, bits[7:0]}, 32'h55);
    check("x55_parity_stop", {30'd0, bits[9:8]}, 32'd3);
    wait_idle("x55_idle");
    check("x55_done", done_cnt - d0, 32'd1);

    // tx_valid with 0xAA while busy must be ignored
    d0 = done_cnt;
    send(8'h3C);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    check("busy_not_ready", {31'd0, tx_ready}, 32'd0);
    repeat (3) @(negedge clock);
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, bits);
    $display("xfer byte=3c (aa ignored) bits=%03h", bits);
    check("3c_data", {24'd0, bits[7:0]}, 32'h3C);
    check("3c_parity_stop", {30'd0, bits[9:8]}, 32'd3);
    wait_idle("3c_idle");
    check("3c_done", done_cnt - d0, 32'd1);

    check("never_both", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
